pipe_stage_elastic: RTL

Parametrised, elastic successor to the fixed MEM/WB-style pipeline registers. It is a generic inter-stage register with a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, a synchronous flush, and a control field that is forced to zero whenever the stage holds a bubble. It is instantiated between any two pipeline stages (IF/ID … MEM/WB) in place of hand-written stage registers. Payload is split into a control field, which is zeroed on bubble, and a data field, which is held.

---
 rtl/pipe_stage_elastic.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: valid/ready handshake, 2-entry skid, flush, bubble-gated control.
// Optional PIPE_STATS_EN macro adds saturating stall/bubble counters.
module pipe_stage_elastic #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              accept, drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE:     if (drain && !accept) state_d = EMPTY;
                 else if (accept && !drain) state_d = FULL;
        FULL:    if (drain) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready comes straight from the state flop, so out_ready never reaches it combinationally
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
  end

  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
        ONE: begin
          if (accept && drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (drain) begin
            main_ctrl_d = '0;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end
        end
        FULL: if (drain) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_ctrl = main_ctrl_q;
  assign out_data = main_data_q;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && stall_q != {CNT_W{1'b1}}) stall_d  = stall_q + 1'b1;
    if (!out_valid && bubble_q != {CNT_W{1'b1}})             bubble_d = bubble_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
